// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-master memory arbiter.
package mem_arb_pkg;

  // Owner IDs as stored in the owner FIFO.
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // Largest supported number of outstanding transactions.
  localparam int unsigned MAX_OUT_LIMIT = 4;

  // Occupancy counter width; it must hold MAX_OUT_LIMIT.
  localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/mem_arbiter_owner_fifo.sv
// One-bit-wide owner FIFO. It records which master issued each accepted
// transaction so that responses can be routed back in order.
module owner_fifo
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             din_i,
  input  logic             pop_i,
  output logic             head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [DEPTH-1:0] mem_q;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_w, pop_w;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // An overflowing push or an underflowing pop is ignored.
  assign push_w = push_i && !full_o;
  assign pop_w  = pop_i && !empty_o;

  // Storage is not reset because the count alone marks entries valid.
  always_ff @(posedge clk) begin
    if (push_w) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointers wrap modulo DEPTH; count tracks push minus pop.
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_w) wr_ptr_q <= (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
      if (pop_w)  rd_ptr_q <= (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
      case ({push_w, pop_w})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter (fetch = I, data = D) in front of one req/gnt/rvalid
// memory port. The request, grant and response paths are purely combinational.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_OUT = 2,
  parameter bit          PRIO_D  = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req_i,
  input  logic [31:0] i_addr_i,
  input  logic        i_we_i,
  input  logic [3:0]  i_be_i,
  input  logic [31:0] i_wdata_i,
  output logic        i_gnt_o,
  output logic        i_rvalid_o,
  output logic [31:0] i_rdata_o,
  input  logic        d_req_i,
  input  logic [31:0] d_addr_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_be_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [2:0]  outstanding_o,
  output logic        idle_o,
  output logic        err_o
);

  logic             lock_valid_q, lock_valid_d;
  logic             lock_owner_q, lock_owner_d;
  logic             prio_q, prio_d;   // preferred owner when both request
  logic             err_q, err_d;
  logic             sel_valid, sel_owner, accept, pop;
  logic             fifo_head, fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  owner_fifo #(.DEPTH(MAX_OUT)) u_owner_fifo (
    .clk     (clk),
    .rst_ni  (reset),
    .push_i  (accept),
    .din_i   (sel_owner),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Pick the master for this cycle: a full FIFO blocks everyone, a pending
  // lock wins next, otherwise fixed or round-robin priority decides.
  always_comb begin
    sel_valid = 1'b0;
    sel_owner = OWN_D;
    if (!fifo_full) begin
      if (lock_valid_q) begin
        sel_valid = 1'b1;
        sel_owner = lock_owner_q;
      end else if (i_req_i && d_req_i) begin
        sel_valid = 1'b1;
        sel_owner = PRIO_D ? OWN_D : prio_q;
      end else if (d_req_i) begin
        sel_valid = 1'b1;
        sel_owner = OWN_D;
      end else if (i_req_i) begin
        sel_valid = 1'b1;
        sel_owner = OWN_I;
      end
    end
  end

  // Route the selected master's payload to memory; zeros when idle.
  always_comb begin
    mem_req_o   = sel_valid;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (sel_valid) begin
      if (sel_owner == OWN_D) begin
        mem_addr_o  = d_addr_i;
        mem_we_o    = d_we_i;
        mem_be_o    = d_be_i;
        mem_wdata_o = d_wdata_i;
      end else begin
        mem_addr_o  = i_addr_i;
        mem_we_o    = i_we_i;
        mem_be_o    = i_be_i;
        mem_wdata_o = i_wdata_i;
      end
    end
  end

  assign accept     = sel_valid && mem_gnt_i;
  assign i_gnt_o    = accept && (sel_owner == OWN_I);
  assign d_gnt_o    = accept && (sel_owner == OWN_D);
  assign pop        = mem_rvalid_i && !fifo_empty;
  assign i_rvalid_o = pop && (fifo_head == OWN_I);
  assign d_rvalid_o = pop && (fifo_head == OWN_D);
  assign i_rdata_o  = mem_rdata_i;
  assign d_rdata_o  = mem_rdata_i;

  assign outstanding_o = fifo_count;
  assign idle_o        = (fifo_count == '0) && !lock_valid_q && !i_req_i && !d_req_i;
  assign err_o         = err_q;

  // Next state: lock an ungranted selection, hand priority to the master
  // that did not just win, and flag any rvalid with nothing outstanding.
  always_comb begin
    lock_valid_d = sel_valid && !mem_gnt_i;
    lock_owner_d = sel_valid ? sel_owner : lock_owner_q;
    prio_d       = accept ? ~sel_owner : prio_q;
    err_d        = err_q | (mem_rvalid_i && fifo_empty);
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lock_valid_q <= 1'b0;
      lock_owner_q <= OWN_D;
      prio_q       <= OWN_D;
      err_q        <= 1'b0;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
      prio_q       <= prio_d;
      err_q        <= err_d;
    end
  end

endmodule
